// File: rtl/srcbuf_ctrl_arb.sv
// Load/serve/drain controller and round-robin read arbiter for one sourcebuffer RAM.
// Optional per-requester grant statistics under `ifdef SRCBUF_ARB_STATS_EN.
// The release pulse is the port release_pulse because "release" is a reserved word.
module srcbuf_ctrl_arb #(
    parameter int NREQ   = 4,
    parameter int AW     = 14,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 load_done,
    input  logic                 release_pulse,
    output logic                 buf_free,
    output logic                 serving,
    input  logic [NREQ-1:0]      rd_valid,
    output logic [NREQ-1:0]      rd_ready,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 buf_wren,
    output logic [AW-1:0]        buf_wraddress,
    output logic [DW-1:0]        buf_data,
    output logic [AW-1:0]        buf_rdaddress,
    input  logic [DW-1:0]        buf_q
`ifdef SRCBUF_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_grants
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic            gnt_found;
    logic            gnt;
    logic            wr_acc;
    logic [RD_LAT:0] pipe_vld;
    logic [IW-1:0]   pipe_id [RD_LAT+1];
    logic            pipe_empty;

    assign pipe_empty = ~|pipe_vld;
    assign wr_ready   = (state == ST_LOAD);
    assign serving    = (state == ST_SERVE);
    assign buf_free   = (state == ST_DRAIN) && pipe_empty;
    assign wr_acc     = wr_valid && wr_ready;
    assign rsp_data   = buf_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (load_done)     state_nxt = ST_SERVE;
            ST_SERVE: if (release_pulse) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pipe_empty)    state_nxt = ST_LOAD;
            default:                     state_nxt = ST_LOAD;
        endcase
    end

    // First requesting index at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_found && rd_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt       = gnt_found && (state == ST_SERVE) && !release_pulse;
    assign rd_ready  = gnt ? (NREQ'(1) << gnt_idx) : '0;
    assign rsp_valid = pipe_vld[RD_LAT] ? (NREQ'(1) << pipe_id[RD_LAT]) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_LOAD;
            rr_ptr        <= '0;
            buf_wren      <= 1'b0;
            buf_wraddress <= '0;
            buf_data      <= '0;
            buf_rdaddress <= '0;
        end else begin
            state    <= state_nxt;
            buf_wren <= wr_acc;
            if (wr_acc) begin
                buf_wraddress <= wr_addr;
                buf_data      <= wr_data;
            end
            if (gnt) begin
                buf_rdaddress <= rd_addr[int'(gnt_idx)*AW +: AW];
                rr_ptr        <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    // NOTE: the response pipe is reset (ids too) so a reset mid-SERVE can never emit a stale response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int k = 0; k <= RD_LAT; k++) pipe_id[k] <= '0;
        end else begin
            pipe_vld   <= {pipe_vld[RD_LAT-1:0], gnt};
            pipe_id[0] <= gnt_idx;
            for (int k = 1; k <= RD_LAT; k++) pipe_id[k] <= pipe_id[k-1];
        end
    end

`ifdef SRCBUF_ARB_STATS_EN
    logic [15:0] stat_cnt [NREQ];

    // Counters restart on every new SERVE phase and saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
        end else if (state == ST_LOAD && load_done) begin
            for (int i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
        end else if (gnt && stat_cnt[gnt_idx] != 16'hFFFF) begin
            stat_cnt[gnt_idx] <= stat_cnt[gnt_idx] + 16'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_srcbuf_ctrl_arb.sv
// Self-checking bench for srcbuf_ctrl_arb: phase-level reference model, response scoreboard and RAM model.
// Build with +define+SRCBUF_ARB_STATS_EN to also check the grant counters.
module tb_srcbuf_ctrl_arb;
    localparam int NREQ = 4, AW = 14, DW = 32, RD_LAT = 1;
    localparam int P_LOAD = 0, P_SERVE = 1, P_DRAIN = 2;

    logic clk = 1'b0;
    logic rst_n, wr_valid, load_done, rel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NREQ-1:0] rd_valid;
    logic [NREQ*AW-1:0] rd_addr;
    logic wr_ready, buf_free, serving, buf_wren;
    logic [NREQ-1:0] rd_ready, rsp_valid;
    logic [DW-1:0] rsp_data, buf_data, buf_q;
    logic [AW-1:0] buf_wraddress, buf_rdaddress;
`ifdef SRCBUF_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
`endif

    srcbuf_ctrl_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .release_pulse(rel), .buf_free(buf_free), .serving(serving),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .buf_wren(buf_wren), .buf_wraddress(buf_wraddress), .buf_data(buf_data),
        .buf_rdaddress(buf_rdaddress), .buf_q(buf_q)
`ifdef SRCBUF_ARB_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Single-clock RAM with one cycle of read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (buf_wren) ram[buf_wraddress] <= buf_data;
        buf_q <= ram[buf_rdaddress];
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    int checks = 0, failures = 0, cyc = 0;
    int ph, ptr, free_seen;
    int stat [NREQ];
    rsp_t rq[$];
    logic [DW-1:0] exp_mem [int];
    logic [AW-1:0] addrs[$];
    logic exp_wren;
    logic [AW-1:0] exp_wa, exp_ra;
    logic [DW-1:0] exp_wd;
    logic [NREQ-1:0] obs_rdy, obs_rsp;
    logic [DW-1:0] obs_data;
    logic obs_wren;
    logic [AW-1:0] obs_wa;
    logic [DW-1:0] obs_wd;

    task automatic model_reset();
        ph = P_LOAD; ptr = 0; rq.delete();
        exp_wren = 1'b0; exp_wa = '0; exp_wd = '0; exp_ra = '0;
        for (int i = 0; i < NREQ; i++) stat[i] = 0;
    endtask

    // One clock cycle: compare every output against the model, then advance the model and the clock.
    task automatic step();
        int g;
        logic [NREQ-1:0] e_rdy, e_rsp;
        logic [DW-1:0] e_dat;
        bit empty, nw, ng;
        logic [AW-1:0] nwa, nra, a;
        logic [DW-1:0] nwd;
        #1;
        g = -1; e_rdy = '0; e_rsp = '0; e_dat = '0; nw = 0; ng = 0; nwa = '0; nwd = '0; nra = '0;
        if (ph == P_SERVE && !rel)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && rd_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        if (g >= 0) e_rdy = 4'b0001 << g;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rsp = 4'b0001 << rq[0].id;
            e_dat = rq[0].data;
        end
        empty = (rq.size() == 0);

        checks++; if (rd_ready !== e_rdy) begin failures++; $display("FAIL rd_ready cyc=%0d got=%b exp=%b", cyc, rd_ready, e_rdy); end
        checks++; if (rsp_valid !== e_rsp) begin failures++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
        if (e_rsp != 0) begin
            checks++; if (rsp_data !== e_dat) begin failures++; $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, e_dat); end
        end
        checks++; if (wr_ready !== (ph == P_LOAD)) begin failures++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, ph == P_LOAD); end
        checks++; if (serving !== (ph == P_SERVE)) begin failures++; $display("FAIL serving cyc=%0d got=%b exp=%b", cyc, serving, ph == P_SERVE); end
        checks++; if (buf_free !== (ph == P_DRAIN && empty)) begin failures++; $display("FAIL buf_free cyc=%0d got=%b exp=%b", cyc, buf_free, ph == P_DRAIN && empty); end
        checks++; if (buf_wren !== exp_wren) begin failures++; $display("FAIL buf_wren cyc=%0d got=%b exp=%b", cyc, buf_wren, exp_wren); end
        if (exp_wren) begin
            checks++; if (buf_wraddress !== exp_wa || buf_data !== exp_wd) begin
                failures++; $display("FAIL buf_write cyc=%0d got=%h/%h exp=%h/%h", cyc, buf_wraddress, buf_data, exp_wa, exp_wd);
            end
        end
        checks++; if (buf_rdaddress !== exp_ra) begin failures++; $display("FAIL buf_rdaddress cyc=%0d got=%h exp=%h", cyc, buf_rdaddress, exp_ra); end

        obs_rdy = rd_ready; obs_rsp = rsp_valid; obs_data = rsp_data;
        obs_wren = buf_wren; obs_wa = buf_wraddress; obs_wd = buf_data;
        if (buf_free === 1'b1) free_seen++;

        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (g >= 0) begin
            a = rd_addr[g*AW +: AW];
            rq.push_back('{due: cyc + 1 + RD_LAT, id: g, data: exp_mem[int'(a)]});
            ptr = (g + 1) % NREQ;
            if (stat[g] < 16'hFFFF) stat[g]++;
            ng = 1; nra = a;
        end
        if (ph == P_LOAD && wr_valid) begin
            exp_mem[int'(wr_addr)] = wr_data;
            addrs.push_back(wr_addr);
            nw = 1; nwa = wr_addr; nwd = wr_data;
        end
        if (ph == P_LOAD && load_done) begin
            ph = P_SERVE;
            for (int i = 0; i < NREQ; i++) stat[i] = 0;
        end else if (ph == P_SERVE && rel) ph = P_DRAIN;
        else if (ph == P_DRAIN && empty) ph = P_LOAD;

        @(posedge clk); #1;
        cyc++;
        exp_wren = nw;
        if (nw) begin exp_wa = nwa; exp_wd = nwd; end
        if (ng) exp_ra = nra;
    endtask

    task automatic rand_rd_addr();
        for (int i = 0; i < NREQ; i++) rd_addr[i*AW +: AW] = addrs[$urandom_range(addrs.size() - 1)];
    endtask

    task automatic check_stats(input string tag);
`ifdef SRCBUF_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (stat_grants[i*16 +: 16] !== 16'(stat[i])) begin
                failures++; $display("FAIL stat_%s req=%0d got=%0d exp=%0d", tag, i, stat_grants[i*16 +: 16], stat[i]);
            end
        end
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 0; load_done = 0; rel = 0; rd_valid = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || rd_ready !== '0 || rsp_valid !== '0 || buf_free !== 1'b0 || serving !== 1'b0 ||
            buf_wren !== 1'b0 || buf_wraddress !== '0 || buf_data !== '0 || buf_rdaddress !== '0) begin
            failures++;
            $display("FAIL reset_outputs got wr_ready=%b rd_ready=%b rsp_valid=%b free=%b serving=%b wren=%b wa=%h wd=%h ra=%h exp only wr_ready=1",
                     wr_ready, rd_ready, rsp_valid, buf_free, serving, buf_wren, buf_wraddress, buf_data, buf_rdaddress);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            wr_valid = (i < 3); wr_addr = AW'(i + 1); wr_data = DW'(23 + 10 * i);
            step();
            if (i > 0) begin
                checks++;
                if (obs_wren !== 1'b1 || obs_wa !== AW'(i) || obs_wd !== DW'(13 + 10 * i)) begin
                    failures++; $display("FAIL load_write%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, obs_wren, obs_wa, obs_wd, i, 13 + 10 * i);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            wr_valid = ($urandom_range(3) != 0); wr_addr = AW'($urandom); wr_data = $urandom;
            rel = ($urandom_range(7) == 0);
            step();
        end
        rel = 0;
        wr_valid = 1; wr_addr = 14'h3fff; wr_data = 32'hcafef00d; load_done = 1;
        step();
        wr_valid = 0; load_done = 0;
        check_stats("load_done");
    endtask

    task automatic test_round_robin();
        rand_rd_addr();
        rd_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (obs_rdy !== (4'b0001 << (k % 4))) begin failures++; $display("FAIL rr_order k=%0d got=%b exp_idx=%0d", k, obs_rdy, k % 4); end
        end
        rd_valid = '0;
        repeat (3) step();
`ifdef SRCBUF_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (stat_grants[i*16 +: 16] !== 16'd2) begin failures++; $display("FAIL rr_stats req=%0d got=%0d exp=2", i, stat_grants[i*16 +: 16]); end
        end
`endif
    endtask

    task automatic test_single_read();
        rd_valid = 4'b0001; rd_addr[0 +: AW] = 14'd1;
        step();
        checks++; if (obs_rdy !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", obs_rdy); end
        rd_valid = '0;
        step();
        checks++; if (obs_rsp !== 4'b0000) begin failures++; $display("FAIL single_early got=%b exp=0000", obs_rsp); end
        step();
        checks++;
        if (obs_rsp !== 4'b0001 || obs_data !== 32'd23) begin failures++; $display("FAIL single_rsp got=%b/%0d exp=0001/23", obs_rsp, obs_data); end
    endtask

    task automatic test_random_serve(input int n);
        for (int i = 0; i < n; i++) begin
            rd_valid = NREQ'($urandom); rand_rd_addr();
            load_done = ($urandom_range(15) == 0);
            step();
        end
        load_done = 0;
        check_stats("random");
    endtask

    task automatic test_release_drain();
        int f0, n;
        rand_rd_addr(); rd_valid = 4'b1111;
        repeat (2) step();
        rel = 1;
        step();
        checks++; if (obs_rdy !== '0) begin failures++; $display("FAIL release_grant got=%b exp=0000", obs_rdy); end
        rel = 0;
        f0 = free_seen; n = 0;
        while (ph != P_LOAD && n < 20) begin step(); n++; end
        checks++; if (ph != P_LOAD) begin failures++; $display("FAIL drain_timeout waited=%0d cycles", n); end
        step();
        checks++; if (free_seen - f0 != 1) begin failures++; $display("FAIL buf_free_count got=%0d exp=1", free_seen - f0); end
        rd_valid = '0;
    endtask

    task automatic test_reset_mid();
        int stale;
        rand_rd_addr(); rd_valid = 4'b1111;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || wr_ready !== 1'b1 || rd_ready !== '0 || serving !== 1'b0) begin
            failures++; $display("FAIL reset_mid got rsp=%b wr_ready=%b rd_ready=%b serving=%b exp 0/1/0/0", rsp_valid, wr_ready, rd_ready, serving);
        end
        model_reset();
        @(posedge clk); #1;
        cyc++;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin step(); if (obs_rsp !== '0) stale++; end
        checks++; if (stale != 0) begin failures++; $display("FAIL stale_rsp got=%0d exp=0", stale); end
        rd_valid = '0;
    endtask

    initial begin
        free_seen = 0;
        test_reset();
        test_load();
        test_round_robin();
        test_single_read();
        test_random_serve(150);
        test_release_drain();
        test_load();
        test_random_serve(60);
        test_reset_mid();
        test_load();
        test_random_serve(40);
        test_release_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
